// File: rtl/avalon_mm_pkg.sv
// Shared sizing helpers and parameter bounds for the Avalon-MM arbiter slice.
package avalon_mm_pkg;

    localparam int NUM_MASTERS_MIN = 2;
    localparam int NUM_MASTERS_MAX = 8;
    localparam int MAX_PENDING_MIN = 2;
    localparam int MAX_PENDING_MAX = 16;

    // Width of a master ID; never zero so a 1-master build still has a real signal.
    function automatic int id_width(input int num_masters);
        return (num_masters <= 2) ? 1 : $clog2(num_masters);
    endfunction

    // Pointer width of a power-of-two deep FIFO.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/avalon_mm_id_fifo.sv
// In-order FIFO of master IDs for outstanding reads; push at full is allowed
// only together with a pop, and a pop on an empty FIFO is ignored.
module avalon_mm_id_fifo
    import avalon_mm_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              din,
    output logic [WIDTH-1:0]              dout,
    output logic                          empty,
    output logic                          full,
    output logic [ptr_width(DEPTH):0]     count
);

    localparam int PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic             push_eff;
    logic             pop_eff;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == (PW+1)'(DEPTH));
    assign count    = count_reg;
    assign dout     = mem_reg[rd_ptr_reg];

    // Pop is evaluated first so that push+pop on an empty FIFO only pushes.
    assign pop_eff  = pop & ~empty;
    assign push_eff = push & (~full | pop_eff);

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop_eff) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push_eff, pop_eff})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/avalon_mm_arbiter.sv
// Round-robin sharing of one Avalon-MM slave between NUM_MASTERS masters,
// with in-order routing of read data back to the issuing master.
module avalon_mm_arbiter
    import avalon_mm_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MAX_PENDING = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
    input  logic [NUM_MASTERS-1:0]            m_read,
    input  logic [NUM_MASTERS-1:0]            m_write,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_writedata,
    output logic [NUM_MASTERS-1:0]            m_waitrequest,
    output logic [DATA_WIDTH-1:0]             m_readdata,
    output logic [NUM_MASTERS-1:0]            m_readdatavalid,
    output logic [ADDR_WIDTH-1:0]             s_address,
    output logic                              s_read,
    output logic                              s_write,
    output logic [DATA_WIDTH-1:0]             s_writedata,
    input  logic [DATA_WIDTH-1:0]             s_readdata,
    input  logic                              s_readdatavalid,
    output logic                              err_unexpected_rdv
);

    localparam int ID_W  = id_width(NUM_MASTERS);
    localparam int CNT_W = ptr_width(MAX_PENDING) + 1;

    typedef logic [ID_W-1:0] mst_id_t;

    logic [NUM_MASTERS-1:0] req_write;
    logic [NUM_MASTERS-1:0] req_read;
    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] grant_onehot;
    logic [NUM_MASTERS-1:0] rdv_onehot;
    logic [ADDR_WIDTH-1:0]  addr_arr [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  wdata_arr [NUM_MASTERS];

    logic                   grant_valid;
    mst_id_t                grant_id;
    mst_id_t                rr_ptr_reg;
    mst_id_t                rr_ptr_next;
    logic                   read_ok;
    logic                   pop_hit;
    logic                   fifo_push;
    mst_id_t                fifo_dout;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [CNT_W-1:0]       pending_count;

    logic [ADDR_WIDTH-1:0]  s_address_reg;
    logic [DATA_WIDTH-1:0]  s_writedata_reg;
    logic                   s_read_reg;
    logic                   s_write_reg;
    logic [DATA_WIDTH-1:0]  m_readdata_reg;
    logic [NUM_MASTERS-1:0] m_readdatavalid_reg;
    logic                   err_reg;

    // A returning read frees a slot in the same cycle, so it may admit a new read.
    assign read_ok = (pending_count < CNT_W'(MAX_PENDING)) | s_readdatavalid;
    assign pop_hit = s_readdatavalid & ~fifo_empty;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            // Read+write together counts as a write only.
            assign req_write[gi]     = m_write[gi];
            assign req_read[gi]      = m_read[gi] & ~m_write[gi];
            assign eligible[gi]      = rst_n & (req_write[gi] | (req_read[gi] & read_ok));
            assign grant_onehot[gi]  = grant_valid & (grant_id == mst_id_t'(gi));
            assign rdv_onehot[gi]    = (fifo_dout == mst_id_t'(gi));
            assign addr_arr[gi]      = m_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi]     = m_writedata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin search starting at the pointer, wrapping modulo NUM_MASTERS.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = (int'(rr_ptr_reg) + k) % NUM_MASTERS;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_id    = mst_id_t'(idx);
            end
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant_valid) begin
            if (int'(grant_id) == NUM_MASTERS - 1) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = grant_id + mst_id_t'(1);
            end
        end
    end

    assign fifo_push     = grant_valid & req_read[grant_id] & (~fifo_full | pop_hit);
    assign m_waitrequest = ~grant_onehot;

    avalon_mm_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_PENDING)
    ) u_id_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (s_readdatavalid),
        .din   (grant_id),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (pending_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_reg          <= '0;
            s_address_reg       <= '0;
            s_writedata_reg     <= '0;
            s_read_reg          <= 1'b0;
            s_write_reg         <= 1'b0;
            m_readdata_reg      <= '0;
            m_readdatavalid_reg <= '0;
            err_reg             <= 1'b0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            if (grant_valid) begin
                s_address_reg   <= addr_arr[grant_id];
                s_writedata_reg <= wdata_arr[grant_id];
                s_read_reg      <= req_read[grant_id];
                s_write_reg     <= req_write[grant_id];
            end else begin
                s_read_reg      <= 1'b0;
                s_write_reg     <= 1'b0;
            end
            m_readdatavalid_reg <= pop_hit ? rdv_onehot : '0;
            if (pop_hit) begin
                m_readdata_reg <= s_readdata;
            end
            // Returns with nothing outstanding are dropped and flagged until reset.
            if (s_readdatavalid && fifo_empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign s_address          = s_address_reg;
    assign s_writedata        = s_writedata_reg;
    assign s_read             = s_read_reg;
    assign s_write            = s_write_reg;
    assign m_readdata         = m_readdata_reg;
    assign m_readdatavalid    = m_readdatavalid_reg;
    assign err_unexpected_rdv = err_reg;

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Vector table, hand-written corner sequences and a randomized run against a
// queue-based reference model of the arbiter.
module tb_avalon_mm_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MP = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*AW-1:0] m_address;
    logic [N-1:0]    m_read;
    logic [N-1:0]    m_write;
    logic [N*DW-1:0] m_writedata;
    logic [N-1:0]    m_waitrequest;
    logic [DW-1:0]   m_readdata;
    logic [N-1:0]    m_readdatavalid;
    logic [AW-1:0]   s_address;
    logic            s_read;
    logic            s_write;
    logic [DW-1:0]   s_writedata;
    logic [DW-1:0]   s_readdata;
    logic            s_readdatavalid;
    logic            err_unexpected_rdv;

    always #5 clk = ~clk;

    avalon_mm_arbiter #(
        .NUM_MASTERS (N),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .MAX_PENDING (MP)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .m_address          (m_address),
        .m_read             (m_read),
        .m_write            (m_write),
        .m_writedata        (m_writedata),
        .m_waitrequest      (m_waitrequest),
        .m_readdata         (m_readdata),
        .m_readdatavalid    (m_readdatavalid),
        .s_address          (s_address),
        .s_read             (s_read),
        .s_write            (s_write),
        .s_writedata        (s_writedata),
        .s_readdata         (s_readdata),
        .s_readdatavalid    (s_readdatavalid),
        .err_unexpected_rdv (err_unexpected_rdv)
    );

    typedef struct packed {
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic        rdv;
        logic [31:0] rdata;
        logic [3:0]  ewait;
        logic        esr;
        logic        esw;
        logic [31:0] esa;
        logic [3:0]  emrdv;
        logic [31:0] emrd;
        logic        eerr;
    } vec_t;

    int total = 0;
    int bad   = 0;

    vec_t tbl [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Fixed addresses for directed tests: m0=0x10, m1=0x20, m2=0x40, m3=0x80.
    task automatic set_fixed_addr();
        m_address   = {32'h80, 32'h40, 32'h20, 32'h10};
        m_writedata = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        m_read          = v.rd;
        m_write         = v.wr;
        s_readdatavalid = v.rdv;
        s_readdata      = v.rdata;
        #4;
        chk({tag, ".wait"}, 32'(m_waitrequest), 32'(v.ewait));
        @(posedge clk);
        #1;
        chk({tag, ".s_read"}, 32'(s_read), 32'(v.esr));
        chk({tag, ".s_write"}, 32'(s_write), 32'(v.esw));
        if (v.esr || v.esw) chk({tag, ".s_address"}, s_address, v.esa);
        chk({tag, ".m_rdv"}, 32'(m_readdatavalid), 32'(v.emrdv));
        if (v.emrdv != 4'b0000) chk({tag, ".m_rdata"}, m_readdata, v.emrd);
        chk({tag, ".err"}, 32'(err_unexpected_rdv), 32'(v.eerr));
        $display("%s: rd=%b wr=%b rdv=%b wait=%b s_rd=%b s_wr=%b addr=%h m_rdv=%b err=%b",
                 tag, v.rd, v.wr, v.rdv, m_waitrequest, s_read, s_write, s_address,
                 m_readdatavalid, err_unexpected_rdv);
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        m_read          = '0;
        m_write         = '0;
        s_readdatavalid = 1'b0;
        s_readdata      = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reference model state for the random phase.
        int          ptr;
        int          q[$];
        logic        merr;
        int          g;
        int          h;
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic        rdv;
        logic [31:0] rdata;
        logic [31:0] addr [N];
        logic [31:0] wd [N];
        logic [3:0]  exp_wait;
        logic [3:0]  exp_mrdv;
        logic [31:0] exp_mrd;
        logic        exp_sr;
        logic        exp_sw;
        logic [31:0] exp_sa;
        logic [31:0] exp_swd;

        set_fixed_addr();
        do_reset();
        chk("reset.wait", 32'(m_waitrequest), 32'hF);
        chk("reset.s_read", 32'(s_read), 32'h0);
        chk("reset.s_write", 32'(s_write), 32'h0);
        chk("reset.s_address", s_address, 32'h0);
        chk("reset.s_writedata", s_writedata, 32'h0);
        chk("reset.m_rdv", 32'(m_readdatavalid), 32'h0);
        chk("reset.m_rdata", m_readdata, 32'h0);
        chk("reset.err", 32'(err_unexpected_rdv), 32'h0);
        rst_n = 1'b1;

        //             rd       wr       rdv   rdata         ewait    esr   esw   esa       emrdv    emrd          eerr
        tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,      4'b1111, 1'b0, 1'b0, 32'h0,  4'b0000, 32'h0,      1'b0};
        tbl[1]  = '{4'b0000, 4'b0011, 1'b0, 32'h0,      4'b1110, 1'b0, 1'b1, 32'h10, 4'b0000, 32'h0,      1'b0};
        tbl[2]  = '{4'b0000, 4'b0011, 1'b0, 32'h0,      4'b1101, 1'b0, 1'b1, 32'h20, 4'b0000, 32'h0,      1'b0};
        tbl[3]  = '{4'b0000, 4'b0011, 1'b0, 32'h0,      4'b1110, 1'b0, 1'b1, 32'h10, 4'b0000, 32'h0,      1'b0};
        tbl[4]  = '{4'b0100, 4'b0000, 1'b0, 32'h0,      4'b1011, 1'b1, 1'b0, 32'h40, 4'b0000, 32'h0,      1'b0};
        tbl[5]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,      4'b1111, 1'b0, 1'b0, 32'h0,  4'b0000, 32'h0,      1'b0};
        tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,      4'b1111, 1'b0, 1'b0, 32'h0,  4'b0000, 32'h0,      1'b0};
        tbl[7]  = '{4'b0000, 4'b0000, 1'b1, 32'hDEAD,   4'b1111, 1'b0, 1'b0, 32'h0,  4'b0100, 32'hDEAD,   1'b0};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,      4'b1111, 1'b0, 1'b0, 32'h0,  4'b0000, 32'h0,      1'b0};
        tbl[9]  = '{4'b1010, 4'b0000, 1'b0, 32'h0,      4'b0111, 1'b1, 1'b0, 32'h80, 4'b0000, 32'h0,      1'b0};
        tbl[10] = '{4'b0010, 4'b0000, 1'b0, 32'h0,      4'b1101, 1'b1, 1'b0, 32'h20, 4'b0000, 32'h0,      1'b0};
        tbl[11] = '{4'b1000, 4'b0000, 1'b0, 32'h0,      4'b0111, 1'b1, 1'b0, 32'h80, 4'b0000, 32'h0,      1'b0};
        tbl[12] = '{4'b0000, 4'b0000, 1'b1, 32'h111,    4'b1111, 1'b0, 1'b0, 32'h0,  4'b1000, 32'h111,    1'b0};
        tbl[13] = '{4'b0000, 4'b0000, 1'b1, 32'h222,    4'b1111, 1'b0, 1'b0, 32'h0,  4'b0010, 32'h222,    1'b0};
        tbl[14] = '{4'b0000, 4'b0000, 1'b1, 32'h333,    4'b1111, 1'b0, 1'b0, 32'h0,  4'b1000, 32'h333,    1'b0};
        tbl[15] = '{4'b0000, 4'b0000, 1'b1, 32'h444,    4'b1111, 1'b0, 1'b0, 32'h0,  4'b0000, 32'h0,      1'b1};
        tbl[16] = '{4'b0000, 4'b0000, 1'b0, 32'h0,      4'b1111, 1'b0, 1'b0, 32'h0,  4'b0000, 32'h0,      1'b1};

        for (int i = 0; i < 17; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Fill all read slots from master 0, then hold, then unblock via a return.
        for (int i = 0; i < MP; i++) begin
            run_vec('{4'b0001, 4'b0000, 1'b0, 32'h0, 4'b1110, 1'b1, 1'b0, 32'h10, 4'b0000, 32'h0, 1'b1},
                    $sformatf("fill%0d", i));
        end
        run_vec('{4'b0001, 4'b0000, 1'b0, 32'h0, 4'b1111, 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1}, "full_hold");
        run_vec('{4'b0001, 4'b0000, 1'b1, 32'h55, 4'b1110, 1'b1, 1'b0, 32'h10, 4'b0001, 32'h55, 1'b1}, "pop_unblock");
        for (int i = 0; i < MP; i++) begin
            run_vec('{4'b0000, 4'b0000, 1'b1, 32'h60 + 32'(i), 4'b1111, 1'b0, 1'b0, 32'h0,
                      4'b0001, 32'h60 + 32'(i), 1'b1}, $sformatf("drain%0d", i));
        end

        // Reset with two reads outstanding.
        run_vec('{4'b0010, 4'b0000, 1'b0, 32'h0, 4'b1101, 1'b1, 1'b0, 32'h20, 4'b0000, 32'h0, 1'b1}, "pend0");
        run_vec('{4'b0010, 4'b0000, 1'b0, 32'h0, 4'b1101, 1'b1, 1'b0, 32'h20, 4'b0000, 32'h0, 1'b1}, "pend1");
        rst_n   = 1'b0;
        m_read  = 4'b0000;
        m_write = 4'b0011;
        #4;
        chk("midrst.wait", 32'(m_waitrequest), 32'hF);
        @(posedge clk);
        #1;
        chk("midrst.s_write", 32'(s_write), 32'h0);
        chk("midrst.s_read", 32'(s_read), 32'h0);
        chk("midrst.err", 32'(err_unexpected_rdv), 32'h0);
        $display("midrst: wait=%b s_wr=%b err=%b", m_waitrequest, s_write, err_unexpected_rdv);
        rst_n = 1'b1;
        run_vec('{4'b0000, 4'b0011, 1'b0, 32'h0, 4'b1110, 1'b0, 1'b1, 32'h10, 4'b0000, 32'h0, 1'b0}, "post_rst_ptr0");
        run_vec('{4'b0000, 4'b0000, 1'b1, 32'h77, 4'b1111, 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1}, "late_rdv");

        // Randomized phase against the reference model.
        do_reset();
        rst_n   = 1'b1;
        ptr     = 0;
        q       = {};
        merr    = 1'b0;
        exp_sa  = '0;
        exp_swd = '0;
        exp_mrd = '0;
        for (int c = 0; c < 300; c++) begin
            rd    = 4'($urandom_range(0, 15));
            wr    = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            rdv   = ((q.size() > 0) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 40) == 0);
            rdata = $urandom;
            for (int i = 0; i < N; i++) begin
                addr[i] = $urandom;
                wd[i]   = $urandom;
                m_address[i*AW +: AW]   = addr[i];
                m_writedata[i*DW +: DW] = wd[i];
            end

            g = -1;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (ptr + k) % N;
                if (g < 0 && (wr[idx] || (rd[idx] && (q.size() < MP || rdv)))) g = idx;
            end
            exp_wait = 4'b1111;
            if (g >= 0) exp_wait[g] = 1'b0;

            exp_mrdv = 4'b0000;
            if (rdv) begin
                if (q.size() > 0) begin
                    h = q.pop_front();
                    exp_mrdv[h] = 1'b1;
                    exp_mrd     = rdata;
                end else begin
                    merr = 1'b1;
                end
            end

            exp_sr = 1'b0;
            exp_sw = 1'b0;
            if (g >= 0) begin
                exp_sw  = wr[g];
                exp_sr  = rd[g] & ~wr[g];
                exp_sa  = addr[g];
                exp_swd = wd[g];
                if (exp_sr) q.push_back(g);
                ptr = (g + 1) % N;
            end

            m_read          = rd;
            m_write         = wr;
            s_readdatavalid = rdv;
            s_readdata      = rdata;
            #4;
            chk("rnd.wait", 32'(m_waitrequest), 32'(exp_wait));
            @(posedge clk);
            #1;
            chk("rnd.s_read", 32'(s_read), 32'(exp_sr));
            chk("rnd.s_write", 32'(s_write), 32'(exp_sw));
            chk("rnd.s_address", s_address, exp_sa);
            chk("rnd.s_writedata", s_writedata, exp_swd);
            chk("rnd.m_rdv", 32'(m_readdatavalid), 32'(exp_mrdv));
            if (exp_mrdv != 4'b0000) chk("rnd.m_rdata", m_readdata, exp_mrd);
            chk("rnd.err", 32'(err_unexpected_rdv), 32'(merr));
            $display("rnd%0d: rd=%b wr=%b rdv=%b wait=%b s_rd=%b s_wr=%b m_rdv=%b pend=%0d",
                     c, rd, wr, rdv, m_waitrequest, s_read, s_write, m_readdatavalid, q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
